// File: rtl/pll_reset_sequencer_if.sv
// ============================================================================
//  Module      : pll_reset_sequencer_if
//  Description : PLL control and system reset/status bundle for the sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface pll_reset_sequencer_if;
    logic       pll_locked_i;
    logic       pll_rst_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       lock_lost_o;
    logic       fail_o;
    logic [7:0] retry_cnt_o;

    // Sequencer side
    modport master (
        input  pll_locked_i,
        output pll_rst_o,
        output sys_rst_o,
        output ready_o,
        output lock_lost_o,
        output fail_o,
        output retry_cnt_o
    );

    // PLL / SoC side
    modport slave (
        output pll_locked_i,
        input  pll_rst_o,
        input  sys_rst_o,
        input  ready_o,
        input  lock_lost_o,
        input  fail_o,
        input  retry_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Pulses PLL reset, waits for lock with timeout/retry, debounces
//                lock, then releases the system reset.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pll_reset_sequencer_if.master bus
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int TO_W    = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_FINAL    = TO_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [TO_W-1:0]  r_timeouts;
    logic [TO_W-1:0]  w_timeouts_nxt;
    logic [7:0]       r_retry_cnt;
    logic [7:0]       w_retry_nxt;
    logic             w_lock_lost_nxt;
    logic [1:0]       r_sync;
    logic             w_lk;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             r_lock_lost;
    logic             r_fail;

    assign w_lk = r_sync[1];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_timeouts_nxt  = r_timeouts;
        w_retry_nxt     = r_retry_cnt;
        w_lock_lost_nxt = 1'b0;

        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
                else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_WAIT_LOCK: begin
                if (w_lk) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_retry_nxt = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;
                    // MAX_RETRIES of zero never gives up, so the timeout tally stays idle.
                    if (MAX_RETRIES != 0 && r_timeouts == TO_FINAL) begin
                        w_state_nxt = ST_FAIL;
                    end else begin
                        w_state_nxt = ST_PLL_RST;
                        if (MAX_RETRIES != 0) w_timeouts_nxt = r_timeouts + TO_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_lk) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_retry_nxt    = 8'd0;
                    w_timeouts_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_lk) begin
                    w_state_nxt     = ST_PLL_RST;
                    w_lock_lost_nxt = 1'b1;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PLL_RST;
            r_cnt       <= '0;
            r_timeouts  <= '0;
            r_retry_cnt <= 8'd0;
            r_sync      <= 2'b00;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timeouts  <= w_timeouts_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_sync      <= {r_sync[0], bus.pll_locked_i};
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST);
            r_sys_rst   <= (w_state_nxt != ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_lock_lost <= w_lock_lost_nxt;
            r_fail      <= (w_state_nxt == ST_FAIL);
        end
    end

    assign bus.pll_rst_o   = r_pll_rst;
    assign bus.sys_rst_o   = r_sys_rst;
    assign bus.ready_o     = r_ready;
    assign bus.lock_lost_o = r_lock_lost;
    assign bus.fail_o      = r_fail;
    assign bus.retry_cnt_o = r_retry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
//  Module      : tb_pll_reset_sequencer
//  Description : Self-checking bench for pll_reset_sequencer (params 4/32/8/2).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 32;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;
    localparam int NVEC  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer_if bus ();
    assign bus.pll_locked_i = locked;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_ST),
        .MAX_RETRIES    (P_MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Reference model: phases with elapsed-cycle bookkeeping.
    typedef enum {M_HOLD, M_SEEK, M_SETTLE, M_UP, M_DEAD} mphase_t;
    mphase_t m_ph = M_HOLD;
    int      m_el = 0;
    int      m_retry = 0;
    int      m_tmo = 0;
    bit      m_lost = 1'b0;
    bit      m_s1 = 1'b0;
    bit      m_s2 = 1'b0;
    bit      m_lk = 1'b0;
    bit      m_valid = 1'b0;
    bit      prev_lost = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = M_HOLD; m_el = 0; m_retry = 0; m_tmo = 0;
            m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0; m_valid = 1'b1;
        end else begin
            m_lk = m_s2;
            m_s2 = m_s1;
            m_s1 = locked;
            m_lost = 1'b0;
            case (m_ph)
                M_HOLD:
                    if (m_el + 1 >= P_RST) begin m_ph = M_SEEK; m_el = 0; end
                    else m_el++;
                M_SEEK:
                    if (m_lk) begin
                        m_ph = M_SETTLE; m_el = 0;
                    end else if (m_el + 1 >= P_TO) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        m_tmo++;
                        m_ph = (P_MR != 0 && m_tmo >= P_MR) ? M_DEAD : M_HOLD;
                        m_el = 0;
                    end else m_el++;
                M_SETTLE:
                    if (!m_lk) begin
                        m_ph = M_SEEK; m_el = 0;
                    end else if (m_el + 1 >= P_ST) begin
                        m_ph = M_UP; m_el = 0; m_retry = 0; m_tmo = 0;
                    end else m_el++;
                M_UP:
                    if (!m_lk) begin m_ph = M_HOLD; m_el = 0; m_lost = 1'b1; end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_pll_rst",   bus.pll_rst_o,   (m_ph == M_HOLD));
            chk("m_sys_rst",   bus.sys_rst_o,   (m_ph != M_UP));
            chk("m_ready",     bus.ready_o,     (m_ph == M_UP));
            chk("m_fail",      bus.fail_o,      (m_ph == M_DEAD));
            chk("m_lock_lost", bus.lock_lost_o, m_lost);
            chk("m_retry",     bus.retry_cnt_o, m_retry);
            chk("inv_rst_order", (!bus.sys_rst_o && bus.pll_rst_o), 0);
            chk("inv_lost_twice", (prev_lost && bus.lock_lost_o), 0);
            prev_lost = bus.lock_lost_o;
        end
    end

    typedef struct {
        bit r;
        bit lk;
        int n;
        bit e_pll;
        bit e_sys;
        bit e_rdy;
        bit e_fail;
        int e_retry;
    } vec_t;

    vec_t vt [NVEC];

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_pll"},   bus.pll_rst_o,   1);
        chk({nm, "_sys"},   bus.sys_rst_o,   1);
        chk({nm, "_rdy"},   bus.ready_o,     0);
        chk({nm, "_lost"},  bus.lock_lost_o, 0);
        chk({nm, "_fail"},  bus.fail_o,      0);
        chk({nm, "_retry"}, bus.retry_cnt_o, 0);
    endtask

    initial begin
        // Lock-acquire path, then lock never arrives: two timeouts into FAIL.
        vt[0]  = '{1, 0,  2, 1, 1, 0, 0, 0};
        vt[1]  = '{0, 0,  3, 1, 1, 0, 0, 0};
        vt[2]  = '{0, 0,  1, 0, 1, 0, 0, 0};
        vt[3]  = '{0, 0, 10, 0, 1, 0, 0, 0};
        vt[4]  = '{0, 1, 10, 0, 1, 0, 0, 0};
        vt[5]  = '{0, 1,  1, 0, 0, 1, 0, 0};
        vt[6]  = '{0, 1,  5, 0, 0, 1, 0, 0};
        vt[7]  = '{1, 0,  1, 1, 1, 0, 0, 0};
        vt[8]  = '{0, 0,  4, 0, 1, 0, 0, 0};
        vt[9]  = '{0, 0, 32, 1, 1, 0, 0, 1};
        vt[10] = '{0, 0,  4, 0, 1, 0, 0, 1};
        vt[11] = '{0, 0, 31, 0, 1, 0, 0, 1};
        vt[12] = '{0, 0,  1, 0, 1, 0, 1, 2};
        vt[13] = '{0, 0, 50, 0, 1, 0, 1, 2};
        vt[14] = '{0, 1, 20, 0, 1, 0, 1, 2};

        for (int i = 0; i < NVEC; i++) begin
            rst    = vt[i].r;
            locked = vt[i].lk;
            tick(vt[i].n);
            chk($sformatf("vec%0d_pll", i),   bus.pll_rst_o,   vt[i].e_pll);
            chk($sformatf("vec%0d_sys", i),   bus.sys_rst_o,   vt[i].e_sys);
            chk($sformatf("vec%0d_rdy", i),   bus.ready_o,     vt[i].e_rdy);
            chk($sformatf("vec%0d_fail", i),  bus.fail_o,      vt[i].e_fail);
            chk($sformatf("vec%0d_retry", i), bus.retry_cnt_o, vt[i].e_retry);
        end

        // Lock glitch during STABLE: back to WAIT_LOCK with no retry counted.
        rst = 1'b1; locked = 1'b0; tick(1);
        chk_reset_vals("fail_exit");
        rst = 1'b0; tick(4);
        chk("glitch_wait_pll", bus.pll_rst_o, 0);
        locked = 1'b1; tick(3);
        tick(3); locked = 1'b0;
        tick(3); locked = 1'b1;
        chk("glitch_retry", bus.retry_cnt_o, 0);
        tick(10);
        chk("glitch_sys_hold", bus.sys_rst_o, 1);
        tick(1);
        chk("glitch_sys_rel", bus.sys_rst_o, 0);
        chk("glitch_ready", bus.ready_o, 1);
        chk("glitch_retry2", bus.retry_cnt_o, 0);

        // One-cycle lock drop in RUN.
        locked = 1'b0; tick(1);
        locked = 1'b1; tick(1);
        chk("lost_early", bus.lock_lost_o, 0);
        chk("lost_early_sys", bus.sys_rst_o, 0);
        tick(1);
        chk("lost_pulse", bus.lock_lost_o, 1);
        chk("lost_sys", bus.sys_rst_o, 1);
        chk("lost_pll", bus.pll_rst_o, 1);
        chk("lost_rdy", bus.ready_o, 0);
        tick(1);
        chk("lost_end", bus.lock_lost_o, 0);
        chk("lost_pll2", bus.pll_rst_o, 1);
        tick(11);
        chk("reseq_not_yet", bus.ready_o, 0);
        tick(1);
        chk("reseq_ready", bus.ready_o, 1);

        // rst in RUN, then rst in STABLE.
        rst = 1'b1; tick(1);
        chk_reset_vals("rst_run");
        rst = 1'b0; tick(3);
        chk("rst_run_pulse", bus.pll_rst_o, 1);
        tick(1);
        chk("rst_run_pulse_end", bus.pll_rst_o, 0);
        tick(3);
        rst = 1'b1; tick(1);
        chk_reset_vals("rst_stable");
        rst = 1'b0; tick(3);
        chk("rst_st_pulse", bus.pll_rst_o, 1);
        tick(1);
        chk("rst_st_pulse_end", bus.pll_rst_o, 0);

        // Random lock toggling with occasional resets, checked by the model.
        for (int c = 0; c < 20000; ) begin
            int hold;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 80) : $urandom_range(1, 24);
            locked = $urandom_range(0, 2) != 0;
            rst = ($urandom_range(0, 49) == 0);
            tick(rst ? 1 : hold);
            rst = 1'b0;
            c += hold;
        end
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
